// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch path.
// Byte order within a memory word is MSB-first: offset 0 is the top byte.
package fetch_pkg;

  localparam int WORD_BYTES = 8;
  localparam int WORD_W     = WORD_BYTES * 8;

  typedef struct packed {
    logic valid;
    logic epoch;
    logic first;
  } inflight_t;

  function automatic logic [7:0] byte_of_word(input logic [WORD_W-1:0] word, input logic [2:0] k);
    return word[WORD_W-1-8*k -: 8];
  endfunction

endpackage

// File: rtl/fetch_byte_ring.sv
// Circular byte buffer: up to 8 compacted bytes written at tail, WIN-byte read window at head.
// Window is combinational from state; caller guarantees no overflow and pops at most occupancy.
module fetch_byte_ring
  import fetch_pkg::*;
#(
  parameter int CAP = 32,
  parameter int WIN = 8,
  localparam int PW = $clog2(CAP)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic [3:0]        wr_cnt_i,
  input  logic [WORD_W-1:0] wr_bytes_i,
  input  logic [PW:0]       pop_i,
  output logic [PW:0]       occ_o,
  output logic [WIN*8-1:0]  win_o
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   occ_q, occ_d;
  logic [7:0]    mem_q [CAP];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      head_d = head_q + pop_i[PW-1:0];
      tail_d = tail_q + PW'(wr_cnt_i);
      occ_d  = occ_q + (PW+1)'(wr_cnt_i) - pop_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Storage is never read beyond occupancy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int j = 0; j < WORD_BYTES; j++) begin
        if (4'(j) < wr_cnt_i) mem_q[tail_q + PW'(j)] <= wr_bytes_i[8*j +: 8];
      end
    end
  end

  always_comb begin
    win_o = '0;
    for (int i = 0; i < WIN; i++) win_o[8*i +: 8] = mem_q[head_q + PW'(i)];
  end

  assign occ_o = occ_q;

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Prefetches aligned 64-bit words into a byte ring and presents up to OUT_BYTES bytes per cycle.
// Outputs are combinational from state; requests stall while ring space (incl. in-flight reads) runs out.
module inst_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int                DATA_W       = 64,
  parameter int                ADDR_W       = 32,
  parameter int                DEPTH_WORDS  = 4,
  parameter int                OUT_BYTES    = 8,
  parameter int                LOAD_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             redirect,
  input  logic [ADDR_W-1:0]                redirect_pc,
  output logic                             mem_req_valid,
  output logic [ADDR_W-1:0]                mem_req_addr,
  input  logic [DATA_W-1:0]                mem_rd_data,
  output logic [OUT_BYTES*8-1:0]           out_bytes,
  output logic [$clog2(OUT_BYTES+1)-1:0]   out_cnt,
  output logic [ADDR_W-1:0]                out_pc,
  input  logic [$clog2(OUT_BYTES+1)-1:0]   consume,
  output logic                             empty
);

  localparam int CAP = DEPTH_WORDS * WORD_BYTES;
  localparam int PW  = $clog2(CAP);
  localparam int CW  = $clog2(OUT_BYTES+1);
  localparam int L   = LOAD_LATENCY;
  localparam int IW  = $clog2(L+1);

  inflight_t         pipe_q [L];
  inflight_t         pipe_d [L];
  logic              epoch_q, epoch_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic [2:0]        drop_q, drop_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [IW-1:0]        inflight;
  logic                 ret_ok;
  logic [2:0]           start;
  logic [3:0]           wr_cnt;
  logic [WORD_W-1:0]    wr_bytes;
  logic [PW:0]          occ;
  logic [OUT_BYTES*8-1:0] win;
  logic [CW-1:0]        eff;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < L; k++) inflight = inflight + IW'(pipe_q[k].valid);
  end

  // Reserve a full word per outstanding read so returning data always fits.
  assign mem_req_valid = rstn && !redirect &&
                         ((32'(occ) + (32'(inflight) << 3) + 32'd8) <= 32'(CAP));
  assign mem_req_addr  = fetch_q;

  assign ret_ok = pipe_q[L-1].valid && (pipe_q[L-1].epoch == epoch_q) && !redirect;
  assign start  = pipe_q[L-1].first ? drop_q : 3'd0;
  assign wr_cnt = ret_ok ? (4'd8 - {1'b0, start}) : 4'd0;

  always_comb begin
    wr_bytes = '0;
    for (int j = 0; j < WORD_BYTES; j++) wr_bytes[8*j +: 8] = byte_of_word(mem_rd_data, start + 3'(j));
  end

  fetch_byte_ring #(.CAP(CAP), .WIN(OUT_BYTES)) u_ring (
    .clk        (clk),
    .rstn       (rstn),
    .flush_i    (redirect),
    .wr_cnt_i   (wr_cnt),
    .wr_bytes_i (wr_bytes),
    .pop_i      ((PW+1)'(eff)),
    .occ_o      (occ),
    .win_o      (win)
  );

  always_comb begin
    out_cnt = (occ >= (PW+1)'(OUT_BYTES)) ? CW'(OUT_BYTES) : CW'(occ);
    eff     = (consume < out_cnt) ? consume : out_cnt;
    empty   = (out_cnt == '0);
    out_pc  = pc_q;
    out_bytes = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (CW'(i) < out_cnt) out_bytes[8*i +: 8] = win[8*i +: 8];
    end
  end

  always_comb begin
    epoch_d = epoch_q;
    first_d = first_q;
    fetch_d = fetch_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    pipe_d[0] = '{valid: mem_req_valid, epoch: epoch_q, first: first_q};
    for (int k = 1; k < L; k++) pipe_d[k] = pipe_q[k-1];
    if (redirect) begin
      epoch_d = ~epoch_q;
      first_d = 1'b1;
      fetch_d = {redirect_pc[ADDR_W-1:3], 3'b000};
      drop_d  = redirect_pc[2:0];
      pc_d    = redirect_pc;
    end else begin
      pc_d = pc_q + ADDR_W'(eff);
      if (mem_req_valid) begin
        fetch_d = fetch_q + ADDR_W'(8);
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < L; k++) pipe_q[k] <= '0;
      epoch_q <= 1'b0;
      first_q <= 1'b1;
      fetch_q <= {RESET_PC[ADDR_W-1:3], 3'b000};
      drop_q  <= RESET_PC[2:0];
      pc_q    <= RESET_PC;
    end else begin
      for (int k = 0; k < L; k++) pipe_q[k] <= pipe_d[k];
      epoch_q <= epoch_d;
      first_q <= first_d;
      fetch_q <= fetch_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Two prefetch buffers (load latency 1 and 3) against a request-table reference model.
// Memory contents are a pure function of byte address, so every presented byte is checkable.
module tb_inst_prefetch_buffer;

  localparam int          L0   = 1;
  localparam int          L1   = 3;
  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'h0000_0103;
  localparam int          CAP  = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [3:0]  consume = '0;

  logic [63:0] rd_data [2];
  logic        req_v   [2];
  logic [31:0] req_a   [2];
  logic [63:0] ob      [2];
  logic [3:0]  oc      [2];
  logic [31:0] opc     [2];
  logic        emp     [2];

  always #5 clk = ~clk;

  inst_prefetch_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH_WORDS(4), .OUT_BYTES(8),
                         .LOAD_LATENCY(L0), .RESET_PC(RPC0)) u_l1 (
    .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(req_v[0]), .mem_req_addr(req_a[0]), .mem_rd_data(rd_data[0]),
    .out_bytes(ob[0]), .out_cnt(oc[0]), .out_pc(opc[0]), .consume(consume), .empty(emp[0]));

  inst_prefetch_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH_WORDS(4), .OUT_BYTES(8),
                         .LOAD_LATENCY(L1), .RESET_PC(RPC1)) u_l3 (
    .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(req_v[1]), .mem_req_addr(req_a[1]), .mem_rd_data(rd_data[1]),
    .out_bytes(ob[1]), .out_cnt(oc[1]), .out_pc(opc[1]), .consume(consume), .empty(emp[1]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: byte stream position, occupancy, and a table of outstanding reads.
  int          m_occ   [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_fetch [2];
  int          m_drop  [2];
  bit          m_first [2];
  int          m_gen   [2];
  bit          p_v     [2][16];
  int          p_due   [2][16];
  int          p_gen   [2][16];
  bit          p_first [2][16];
  bit          q_v     [2][16];
  int          q_due   [2][16];
  logic [31:0] q_addr  [2][16];

  function automatic logic [7:0] byte_fn(input logic [31:0] a);
    return a[7:0] ^ (a[15:8] * 8'd7) ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [63:0] word_fn(input logic [31:0] w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[63-8*k -: 8] = byte_fn(w + 32'(k));
    return r;
  endfunction

  function automatic int lat(input int n);
    return (n == 0) ? L0 : L1;
  endfunction

  function automatic logic [31:0] rpc(input int n);
    return (n == 0) ? RPC0 : RPC1;
  endfunction

  task automatic chk(input string tag, input int n, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s u%0d cyc=%0d got=%h exp=%h", tag, n, cyc, obs, exp);
    end
  endtask

  task automatic model_reset(input int n);
    logic [31:0] r;
    r = rpc(n);
    m_occ[n]   = 0;
    m_pc[n]    = r;
    m_fetch[n] = r & 32'hFFFF_FFF8;
    m_drop[n]  = int'(r[2:0]);
    m_first[n] = 1'b1;
    m_gen[n]   = m_gen[n] + 1;
    for (int k = 0; k < 16; k++) begin
      p_v[n][k] = 1'b0;
      q_v[n][k] = 1'b0;
    end
  endtask

  task automatic model_now(input int n, output int cnt, output bit req);
    int infl;
    infl = 0;
    for (int k = 0; k < 16; k++) if (p_v[n][k]) infl++;
    cnt = (m_occ[n] < 8) ? m_occ[n] : 8;
    req = rstn && !redirect && (m_occ[n] + 8*infl + 8 <= CAP);
  endtask

  task automatic check_outputs(input int n);
    int cnt;
    bit req;
    logic [63:0] eb;
    model_now(n, cnt, req);
    eb = '0;
    for (int i = 0; i < cnt; i++) eb[8*i +: 8] = byte_fn(m_pc[n] + 32'(i));
    chk("out_pc", n, 64'(opc[n]), 64'(m_pc[n]));
    chk("out_cnt", n, 64'(oc[n]), 64'(cnt));
    chk("empty", n, 64'(emp[n]), 64'(cnt == 0));
    chk("req_vld", n, 64'(req_v[n]), 64'(req));
    if (req) chk("req_addr", n, 64'(req_a[n]), 64'(m_fetch[n]));
    chk("out_bytes", n, ob[n], eb);
  endtask

  task automatic model_adv(input int n);
    int cnt, eff, written;
    bit req;
    model_now(n, cnt, req);
    written = 0;
    for (int k = 0; k < 16; k++) begin
      if (p_v[n][k] && p_due[n][k] == cyc) begin
        if (p_gen[n][k] == m_gen[n] && !redirect) written = p_first[n][k] ? 8 - m_drop[n] : 8;
        p_v[n][k] = 1'b0;
      end
    end
    if (redirect) begin
      m_occ[n]   = 0;
      m_pc[n]    = redirect_pc;
      m_fetch[n] = redirect_pc & 32'hFFFF_FFF8;
      m_drop[n]  = int'(redirect_pc[2:0]);
      m_first[n] = 1'b1;
      m_gen[n]   = m_gen[n] + 1;
    end else begin
      eff = (int'(consume) < cnt) ? int'(consume) : cnt;
      m_occ[n] = m_occ[n] + written - eff;
      m_pc[n]  = m_pc[n] + 32'(eff);
      if (req) begin
        for (int k = 0; k < 16; k++) begin
          if (!p_v[n][k]) begin
            p_v[n][k] = 1'b1; p_due[n][k] = cyc + lat(n);
            p_gen[n][k] = m_gen[n]; p_first[n][k] = m_first[n];
            break;
          end
        end
        m_fetch[n] = m_fetch[n] + 32'd8;
        m_first[n] = 1'b0;
      end
    end
  endtask

  task automatic mem_drive(input int n);
    rd_data[n] = {$urandom, $urandom};
    for (int k = 0; k < 16; k++) begin
      if (q_v[n][k] && q_due[n][k] == cyc) begin
        rd_data[n] = word_fn(q_addr[n][k]);
        q_v[n][k] = 1'b0;
      end
    end
  endtask

  task automatic mem_capture(input int n);
    if (req_v[n] === 1'b1) begin
      for (int k = 0; k < 16; k++) begin
        if (!q_v[n][k]) begin
          q_v[n][k] = 1'b1; q_due[n][k] = cyc + lat(n); q_addr[n][k] = req_a[n];
          break;
        end
      end
    end
  endtask

  task automatic step(input int c, input bit rd, input logic [31:0] pc);
    @(negedge clk);
    rstn = 1'b1;
    consume = 4'(c);
    redirect = rd;
    redirect_pc = pc;
    for (int n = 0; n < 2; n++) mem_drive(n);
    #1;
    for (int n = 0; n < 2; n++) begin
      check_outputs(n);
      mem_capture(n);
      model_adv(n);
    end
    cyc++;
  endtask

  task automatic rst_step();
    @(negedge clk);
    rstn = 1'b0;
    consume = '0;
    redirect = 1'b0;
    for (int n = 0; n < 2; n++) mem_drive(n);
    #1;
    for (int n = 0; n < 2; n++) begin
      model_reset(n);
      check_outputs(n);
    end
    cyc++;
  endtask

  initial begin
    int since;
    for (int n = 0; n < 2; n++) begin
      rd_data[n] = '0;
      m_gen[n] = 0;
      model_reset(n);
    end
    repeat (3) rst_step();

    repeat (8) step(0, 1'b0, '0);
    repeat (20) step(8, 1'b0, '0);

    step(0, 1'b1, 32'h0000_1005);
    repeat (6) step(0, 1'b0, '0);

    repeat (40) step(3, 1'b0, '0);

    step(0, 1'b1, 32'h0000_2006);
    step(0, 1'b0, '0);
    step(0, 1'b0, '0);
    repeat (5) step(8, 1'b0, '0);

    step(0, 1'b1, 32'hFFFF_FFFA);
    repeat (10) step($urandom_range(0, 8), 1'b0, '0);

    since = 0;
    repeat (80) begin
      if ($urandom_range(0, 15) == 0 && since > 4) begin
        step($urandom_range(0, 8), 1'b1, $urandom);
        since = 0;
      end else begin
        step($urandom_range(0, 8), 1'b0, '0);
        since++;
      end
    end

    repeat (2) rst_step();
    repeat (30) step($urandom_range(0, 8), 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
